// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM-stage load/store port: serialized word access after LATENCY cycles.
// Optional build macro DMEM_BYTE_STRB_EN adds wstrb_i for byte-masked stores.
module dmem_responder #(
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter int unsigned LATENCY    = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
`ifdef DMEM_BYTE_STRB_EN
    input  logic [3:0]  wstrb_i,
`endif
    output logic        ready_o,
    output logic        stall_o,
    output logic        resp_valid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                accept;
    logic                access;

    logic                we_q;
    logic [DATA_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;

    logic                from_live;
    logic                acc_we;
    logic [DATA_W-1:0]   acc_addr;
    logic [DATA_W-1:0]   acc_wdata;
    logic [DEPTH_LOG2-1:0] acc_idx;
    logic                misaligned;
    logic                unused_addr_bits;

`ifdef DMEM_BYTE_STRB_EN
    logic [3:0]          wstrb_q;
    logic [3:0]          acc_strb;
`endif

    logic [DATA_W-1:0]   mem [DEPTH];

    // Next-state and combinational handshake outputs
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        ready_o = 1'b0;
        stall_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                stall_o = req_i;
                if (req_i) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_W'(LATENCY - 2);
                    end
                end
            end
            BUSY: begin
                stall_o = 1'b1;
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The array is touched only on the edge entering RESP; LATENCY=1 enters straight from IDLE
    assign access    = (state_d == RESP);
    assign from_live = (state_q == IDLE);
    assign acc_we    = from_live ? we_i    : we_q;
    assign acc_addr  = from_live ? addr_i  : addr_q;
    assign acc_wdata = from_live ? wdata_i : wdata_q;
`ifdef DMEM_BYTE_STRB_EN
    assign acc_strb  = from_live ? wstrb_i : wstrb_q;
`endif

    assign acc_idx          = acc_addr[DEPTH_LOG2+1:2];
    assign misaligned       = |acc_addr[1:0];
    assign unused_addr_bits = ^acc_addr[DATA_W-1:DEPTH_LOG2+2];

    // Control state and registered response outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            resp_valid_o <= 1'b0;
            err_o        <= 1'b0;
            rdata_o      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_valid_o <= access;
            err_o        <= access & misaligned;
            if (access) begin
                rdata_o <= (acc_we || misaligned) ? '0 : mem[acc_idx];
            end
        end
    end

    // Request capture at accept
    always_ff @(posedge clk_i) begin
        if (accept) begin
            we_q    <= we_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
`ifdef DMEM_BYTE_STRB_EN
            wstrb_q <= wstrb_i;
`endif
        end
    end

    // Store path; a reset on the access edge discards the store
    always_ff @(posedge clk_i) begin
        if (!rst_i && access && acc_we && !misaligned) begin
`ifdef DMEM_BYTE_STRB_EN
            for (int b = 0; b < 4; b++) begin
                if (acc_strb[b]) begin
                    mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
                end
            end
`else
            mem[acc_idx] <= acc_wdata;
`endif
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: u0 with LATENCY=4, u1 with LATENCY=1, checked against a word-array model.
// Build with DMEM_BYTE_STRB_EN to also exercise byte strobes.
module tb_dmem_responder;

    localparam int unsigned LAT0  = 4;
    localparam int unsigned LAT1  = 1;
    localparam int unsigned WORDS = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [1:0]       req, we;
    logic [1:0][31:0] addr, wdata;
    logic [1:0]       ready, stall, rv, err;
    logic [1:0][31:0] rdata;
`ifdef DMEM_BYTE_STRB_EN
    logic [1:0][3:0]  wstrb;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0] ref_mem [2][WORDS];
    logic [32:0] q0[$];
    logic [32:0] q1[$];
    logic [32:0] mon_e0, mon_e1;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_LOG2(8), .LATENCY(LAT0)) u0 (
        .clk_i(clk), .rst_i(rst), .req_i(req[0]), .we_i(we[0]),
        .addr_i(addr[0]), .wdata_i(wdata[0]),
`ifdef DMEM_BYTE_STRB_EN
        .wstrb_i(wstrb[0]),
`endif
        .ready_o(ready[0]), .stall_o(stall[0]), .resp_valid_o(rv[0]),
        .rdata_o(rdata[0]), .err_o(err[0])
    );

    dmem_responder #(.DEPTH_LOG2(8), .LATENCY(LAT1)) u1 (
        .clk_i(clk), .rst_i(rst), .req_i(req[1]), .we_i(we[1]),
        .addr_i(addr[1]), .wdata_i(wdata[1]),
`ifdef DMEM_BYTE_STRB_EN
        .wstrb_i(wstrb[1]),
`endif
        .ready_o(ready[1]), .stall_o(stall[1]), .resp_valid_o(rv[1]),
        .rdata_o(rdata[1]), .err_o(err[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: word array indexed modulo its size; returns {err, rdata}
    task automatic model(input int inst, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s, output logic [32:0] res);
        int idx;
        idx = int'((a >> 2) % 32'(WORDS));
        if (a[1:0] != 2'b00) begin
            res = {1'b1, 32'h0};
        end else if (w) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) ref_mem[inst][idx][8*b +: 8] = d[8*b +: 8];
            res = 33'h0;
        end else begin
            res = {1'b0, ref_mem[inst][idx]};
        end
    endtask

    task automatic push(input int inst, input logic [32:0] res);
        if (inst == 0) q0.push_back(res);
        else           q1.push_back(res);
    endtask

    // One isolated transaction with latency and stall-length checks
    task automatic txn(input int inst, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
        logic [32:0] res;
        int lat, sc, rk;
        bit done;
        lat = (inst == 0) ? LAT0 : LAT1;
        sc = 0; rk = -1; done = 1'b0;
        @(negedge clk);
        #1;
        chk("ready_before_req", 32'(ready[inst]), 32'd1);
        req[inst] = 1'b1; we[inst] = w; addr[inst] = a; wdata[inst] = d;
`ifdef DMEM_BYTE_STRB_EN
        wstrb[inst] = s;
`endif
        model(inst, w, a, d, s, res);
        push(inst, res);
        for (int k = 0; k < 40 && !done; k++) begin
            #1;
            if (rv[inst]) begin
                rk = k;
                done = 1'b1;
            end else begin
                if (stall[inst]) sc++;
                @(negedge clk);
                req[inst] = 1'b0;
            end
        end
        req[inst] = 1'b0;
        chk("latency", 32'(rk), 32'(lat));
        chk("stall_cycles", 32'(sc), 32'(lat));
        chk("stall_in_resp", 32'(stall[inst]), 32'd0);
        @(negedge clk);
        #1;
        chk("rv_one_cycle", 32'(rv[inst]), 32'd0);
        chk("err_clear", 32'(err[inst]), 32'd0);
        chk("rdata_hold", rdata[inst], res[31:0]);
        chk("ready_after", 32'(ready[inst]), 32'd1);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rv[0]) begin
            if (q0.size() == 0) chk("unexpected_resp0", 32'(rv[0]), 32'd0);
            else begin
                mon_e0 = q0.pop_front();
                chk("err0", 32'(err[0]), 32'(mon_e0[32]));
                chk("rdata0", rdata[0], mon_e0[31:0]);
            end
        end
        if (rv[1]) begin
            if (q1.size() == 0) chk("unexpected_resp1", 32'(rv[1]), 32'd0);
            else begin
                mon_e1 = q1.pop_front();
                chk("err1", 32'(err[1]), 32'(mon_e1[32]));
                chk("rdata1", rdata[1], mon_e1[31:0]);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] v, a, old, d;
        logic [32:0] res;
        logic [3:0]  s;
        int inst;
        bit w, saw;

        req = '0; we = '0; addr = '0; wdata = '0;
`ifdef DMEM_BYTE_STRB_EN
        wstrb = '1;
`endif
        for (int i = 0; i < int'(WORDS); i++) begin
            v = $urandom; ref_mem[0][i] = v; u0.mem[i] = v;
            v = $urandom; ref_mem[1][i] = v; u1.mem[i] = v;
        end
        ref_mem[0][4] = 32'hDEADBEEF; u0.mem[4] = 32'hDEADBEEF;
        ref_mem[1][0] = 32'hCAFEF00D; u1.mem[0] = 32'hCAFEF00D;

        repeat (3) @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_ready", 32'(ready[i]), 32'd1);
            chk("rst_stall", 32'(stall[i]), 32'd0);
            chk("rst_rv", 32'(rv[i]), 32'd0);
            chk("rst_rdata", rdata[i], 32'd0);
            chk("rst_err", 32'(err[i]), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Directed loads/stores on the LATENCY=4 instance
        txn(0, 1'b0, 32'h10, 32'h0, 4'hF);
        chk("load_deadbeef", rdata[0], 32'hDEADBEEF);
        txn(0, 1'b1, 32'h20, 32'h12345678, 4'hF);
        txn(0, 1'b0, 32'h20, 32'h0, 4'hF);
        chk("store_then_load", rdata[0], 32'h12345678);
        txn(0, 1'b0, 32'h22, 32'h0, 4'hF);
        chk("misaligned_rdata", rdata[0], 32'h0);
        txn(0, 1'b0, 32'h20, 32'h0, 4'hF);
        chk("after_misaligned", rdata[0], 32'h12345678);

        // Reset in the second BUSY cycle of a store
        old = ref_mem[0][12];
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h30; wdata[0] = 32'hAAAA5555;
        @(negedge clk);
        req[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("abort_ready", 32'(ready[0]), 32'd1);
        chk("abort_stall", 32'(stall[0]), 32'd0);
        chk("abort_rv", 32'(rv[0]), 32'd0);
        rst = 1'b0;
        saw = 1'b0;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (rv[0]) saw = 1'b1;
        end
        chk("abort_no_resp", 32'(saw), 32'd0);
        txn(0, 1'b0, 32'h30, 32'h0, 4'hF);
        chk("abort_old_value", rdata[0], old);

`ifdef DMEM_BYTE_STRB_EN
        ref_mem[0][16] = 32'h11223344; u0.mem[16] = 32'h11223344;
        txn(0, 1'b1, 32'h40, 32'hAABBCCDD, 4'b0101);
        txn(0, 1'b0, 32'h40, 32'h0, 4'hF);
        chk("strobe_merge", rdata[0], 32'h11BB33DD);
        wstrb = '1;
`endif

        // Back-to-back loads with req held high on the LATENCY=1 instance
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = (i == 0) ? 32'h000 : (i == 1) ? 32'h400 : 32'hC08;
            addr[1] = a;
            model(1, 1'b0, a, 32'h0, 4'hF, res);
            push(1, res);
            #1;
            chk("b2b_idle_stall", 32'(stall[1]), 32'd1);
            chk("b2b_idle_rv", 32'(rv[1]), 32'd0);
            @(negedge clk);
            #1;
            chk("b2b_resp", 32'(rv[1]), 32'd1);
            chk("b2b_resp_stall", 32'(stall[1]), 32'd0);
            if (i < 2) chk("b2b_wrap", rdata[1], 32'hCAFEF00D);
            @(negedge clk);
        end
        req[1] = 1'b0;

        // Randomized traffic on both instances
        for (int n = 0; n < 60; n++) begin
            inst = int'($urandom_range(1, 0));
            w = 1'($urandom_range(1, 0));
            a = $urandom;
            if ($urandom_range(3, 0) != 0) a[1:0] = 2'b00;
            d = $urandom;
`ifdef DMEM_BYTE_STRB_EN
            s = 4'($urandom);
`else
            s = 4'hF;
`endif
            repeat ($urandom_range(2, 0)) @(negedge clk);
            txn(inst, w, a, d, s);
        end

        repeat (3) @(negedge clk);
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory responder on the far end of the CPU MEM-stage load/store interface.
- Accepts one request per transaction from the pipeline's MEM stage. Performs a word read or write into an internal word array after a fixed latency.
- Returns a one-cycle response and drives a stall line that freezes the pipeline while the access is in flight.

Parameters:
DEPTH_LOG2, 8, log2 of word count (256 words, byte address range 0x000-0x3FF)
LATENCY, 4, cycles from accept edge to resp_valid_o cycle; legal 1..15

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  synchronous reset, active-high
req_i  in  1  request present (MEM-stage load or store)
we_i  in  1  1 = store, 0 = load
addr_i  in  32  byte address
wdata_i  in  32  store data
ready_o  out  1  responder idle, request will be accepted this cycle
stall_o  out  1  pipeline freeze request
resp_valid_o  out  1  one-cycle response strobe
rdata_o  out  32  load data, valid while resp_valid_o=1
err_o  out  1  misaligned access flag, valid with resp_valid_o

Behaviour:
- FSM states: IDLE, BUSY, RESP. Internal regs: state, cnt[3:0], latched we/addr/wdata.
- Reset (rst_i=1 at edge) values:
  - state=IDLE, cnt=0, rdata_o=0, resp_valid_o=0, err_o=0.
  - Memory array is not cleared; the bench preloads it hierarchically.
- Reset mid-operation aborts the transaction. A pending store is discarded and no response is issued.
- IDLE:
  - ready_o=1.
  - Accept on an edge where req_i=1. Latch we_i/addr_i/wdata_i.
  - If LATENCY=1, go to RESP. Otherwise go to BUSY with cnt=LATENCY-2.
- BUSY:
  - ready_o=0.
  - If cnt=0, go to RESP. Otherwise decrement cnt.
  - req_i is ignored.
- Array access is performed on the edge entering RESP, using latched values (for LATENCY=1, the live inputs).
- Word index = addr[DEPTH_LOG2+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*2^DEPTH_LOG2.
- Store: array[index] <= wdata. rdata_o <= 0.
- Load: rdata_o <= array[index].
- Misaligned (addr[1:0]!=0): no array write. rdata_o <= 0. err_o <= 1.
- RESP:
  - resp_valid_o=1 and ready_o=0 for exactly one cycle, then IDLE.
  - rdata_o holds its value until the next RESP entry or reset.
  - err_o and resp_valid_o clear on leaving RESP.
- stall_o (combinational) = (state==IDLE & req_i) | (state==BUSY). stall_o is 0 in RESP so the pipeline advances in the cycle the data is valid.
- Total latency: request accepted at edge E; resp_valid_o high in the cycle after edge E+LATENCY-1. stall_o is high for exactly LATENCY cycles per transaction.
- Back-to-back requests: after RESP the FSM returns to IDLE. A req_i held high is accepted on the next edge, giving a 1-cycle IDLE gap with stall_o=1.
- Load after store to the same address returns the stored value; there is no hazard because accesses are serialized.

Optional Feature:
DMEM_BYTE_STRB_EN:
- Defined: adds input wstrb_i[3:0]. A store writes only the bytes whose strobe bit is 1, with wstrb_i latched at accept. A store with wstrb_i=0 leaves the array unchanged but still responds. Misaligned rule unchanged.
- Undefined: port absent; every store writes the full word.

Test Plan:
- LATENCY=4, reset, then load addr 0x10 with preloaded 0xDEADBEEF:
  - stall_o high 4 cycles.
  - resp_valid_o single pulse in cycle 4 after accept.
  - rdata_o=0xDEADBEEF, err_o=0.
- Store 0x12345678 to 0x20, then load 0x20 -> load returns 0x12345678; rdata_o=0 during the store response.
- Load 0x22 (misaligned) -> err_o=1 with resp_valid_o, rdata_o=0. A following load of 0x20 still returns the prior contents.
- Assert rst_i in the 2nd BUSY cycle of a store of 0xAAAA5555 to 0x30:
  - No resp_valid_o.
  - Next cycle ready_o=1, stall_o=0 (req_i low).
  - Load 0x30 returns the old value.
- LATENCY=1, req_i held high for 3 loads:
  - resp_valid_o every second cycle.
  - Address 0x400 returns the same word as 0x000 (wrap).
- With DMEM_BYTE_STRB_EN: word 0x11223344, store 0xAABBCCDD with wstrb_i=4'b0101 -> load returns 0x11BB33DD.
